// File: rtl/scale_sched.sv
`default_nettype none
// ============================================================================
// Module   : scale_sched
// Purpose  : Sequencer for the requantization scale unit. Streams accumulator
//            beats into scale, attaching the per-channel multiplier m, shift n
//            (looked up in a small channel table) and the layer ReLU enable.
//            Tracks channel/pixel position and results still in flight, and
//            pulses done once every issued beat has returned as s_valid.
// Ports    : clk, rst_n                   - clock, async active-low reset
//            cfg_start/ch_num/pix_num/relu - layer configuration (IDLE only)
//            tab_we/addr/m/n              - channel-table write port (IDLE only)
//            acc_data/valid/ready         - accumulator beat stream in
//            sc_m_data1/m_data2/n/relu_en/m_valid1 - issue towards scale
//            sc_s_valid                   - result-return pulse from scale
//            busy, done                   - layer status
// Revision : 1.0 - initial release
// ============================================================================
module scale_sched #(
    parameter int DW    = 22,
    parameter int DN    = 1,
    parameter int CH_AW = 4,
    parameter int CNT_W = 16,
    parameter int OS_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic [CH_AW:0]      cfg_ch_num,
    input  logic [CNT_W-1:0]    cfg_pix_num,
    input  logic                cfg_relu,
    input  logic                tab_we,
    input  logic [CH_AW-1:0]    tab_addr,
    input  logic [8:0]          tab_m,
    input  logic [4:0]          tab_n,
    input  logic [DN*DW-1:0]    acc_data,
    input  logic                acc_valid,
    output logic                acc_ready,
    output logic [DN*DW-1:0]    sc_m_data1,
    output logic [DN*9-1:0]     sc_m_data2,
    output logic [4:0]          sc_n,
    output logic                sc_relu_en,
    output logic                sc_m_valid1,
    input  logic                sc_s_valid,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [OS_W-1:0] C_OS_MAX = {OS_W{1'b1}};
    localparam int              C_DEPTH  = 2 ** CH_AW;

    state_t             r_state;
    state_t             w_state_nxt;

    // Channel table entry layout: {m[8:0], n[4:0]}
    logic [13:0]        r_tab [C_DEPTH];

    logic [CH_AW:0]     r_ch_num;
    logic [CNT_W-1:0]   r_pix_num;
    logic               r_relu;
    logic [CH_AW-1:0]   r_ch_idx;
    logic [CNT_W-1:0]   r_pix_cnt;
    logic [OS_W-1:0]    r_os_cnt;
    logic               r_done_zero;

    logic               w_start;
    logic               w_zero_cfg;
    logic               w_accept;
    logic               w_last_pix;
    logic               w_last_beat;
    logic               w_os_full;
    logic               w_ret;
    logic               w_drain_done;
    logic [13:0]        w_entry;

    assign w_start      = (r_state == IDLE) && cfg_start;
    assign w_zero_cfg   = (cfg_ch_num == '0) || (cfg_pix_num == '0);
    assign w_accept     = acc_valid && acc_ready;
    assign w_last_pix   = (r_pix_cnt == r_pix_num - 1'b1);
    assign w_last_beat  = w_last_pix && ({1'b0, r_ch_idx} == r_ch_num - 1'b1);
    assign w_entry      = r_tab[r_ch_idx];

    // The counter lags an accept by one cycle (it counts issues), so a beat
    // already registered for issue is counted ahead of time here; otherwise
    // an accept at MAX-1 with an issue pending would overflow the counter.
    assign w_os_full    = (r_os_cnt == C_OS_MAX) ||
                          (sc_m_valid1 && (r_os_cnt == C_OS_MAX - 1'b1));

    // A return is honoured only if something is in flight; a return coinciding
    // with an issue cancels it out, so that case is honoured too.
    assign w_ret        = sc_s_valid && ((r_os_cnt != '0) || sc_m_valid1);

    // Completion is decided combinationally so done lands one cycle after the
    // final s_valid.
    assign w_drain_done = (r_state == DRAIN) && (r_os_cnt == '0) && !sc_m_valid1;

    assign done         = r_done_zero | w_drain_done;

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        acc_ready   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start && !w_zero_cfg) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                acc_ready = !w_os_full;
                if (w_accept && w_last_beat) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = !w_drain_done;
                if (w_drain_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Channel table (contents intentionally not reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && tab_we) begin
            r_tab[tab_addr] <= {tab_m, tab_n};
        end
    end

    // ------------------------------------------------------------------------
    // Configuration, position counters and issue registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch_num    <= '0;
            r_pix_num   <= '0;
            r_relu      <= 1'b0;
            r_ch_idx    <= '0;
            r_pix_cnt   <= '0;
            r_done_zero <= 1'b0;
            sc_m_data1  <= '0;
            sc_m_data2  <= '0;
            sc_n        <= '0;
            sc_relu_en  <= 1'b0;
            sc_m_valid1 <= 1'b0;
        end else begin
            r_done_zero <= w_start && w_zero_cfg;
            sc_m_valid1 <= w_accept;
            if (w_start) begin
                r_ch_num  <= cfg_ch_num;
                r_pix_num <= cfg_pix_num;
                r_relu    <= cfg_relu;
                r_ch_idx  <= '0;
                r_pix_cnt <= '0;
            end else if (w_accept) begin
                sc_m_data1 <= acc_data;
                sc_m_data2 <= {DN{w_entry[13:5]}};
                sc_n       <= w_entry[4:0];
                sc_relu_en <= r_relu;
                if (w_last_pix) begin
                    r_pix_cnt <= '0;
                    r_ch_idx  <= r_ch_idx + 1'b1;
                end else begin
                    r_pix_cnt <= r_pix_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outstanding-result counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_os_cnt <= '0;
        end else if (w_start) begin
            r_os_cnt <= '0;
        end else begin
            case ({sc_m_valid1, w_ret})
                2'b10:   r_os_cnt <= r_os_cnt + 1'b1;
                2'b01:   r_os_cnt <= r_os_cnt - 1'b1;
                default: r_os_cnt <= r_os_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire
